alu_pipe_cc: RTL and testbench

- Parametrised, registered Y86 execute-stage ALU.
- Performs the four OPq functions (ADD, SUB, AND, XOR) at a configurable width.
- Holds the result in a one-deep output register behind a valid/ready handshake.
- Maintains the architected condition-code register (ZF, SF, OF); supersedes the standalone combinational bitwise blocks in the ALU.

---
 rtl/alu_pipe_cc.sv | 102 ++++++++++
 tb/tb_alu_pipe_cc.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_cc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pipe_cc : registered Y86 OPq ALU with valid/ready output stage and   |
// |               architected {ZF,SF,OF} condition-code register.            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module alu_pipe_cc #(
  parameter int          WIDTH    = 64,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_cc,
  output logic [2:0]       cc_q
);

  localparam logic [1:0] c_OP_ADD = 2'd0;
  localparam logic [1:0] c_OP_SUB = 2'd1;
  localparam logic [1:0] c_OP_AND = 2'd2;
  localparam logic [1:0] c_OP_XOR = 2'd3;

  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       occ_q,    occ_d;
  logic [2:0]       cc_d;

  logic [WIDTH-1:0] w_res;
  logic             w_of;
  logic [2:0]       w_flags;
  logic             w_accept;

  assign in_ready = !valid_q || out_ready;
  // A flush squashes the buffered result and whatever is offered alongside it.
  assign w_accept = in_valid && in_ready && !flush;

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (in_op)
      c_OP_ADD: begin
        w_res = in_b + in_a;
        w_of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = in_b - in_a;
        w_of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_b[WIDTH-1]);
      end
      c_OP_AND: w_res = in_b & in_a;
      c_OP_XOR: w_res = in_b ^ in_a;
      default:  w_res = '0;
    endcase
  end

  assign w_flags = {(w_res == '0), w_res[WIDTH-1], w_of};

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    occ_d    = occ_q;
    cc_d     = cc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d  = 1'b1;
      result_d = w_res;
      occ_d    = w_flags;
      if (in_set_cc) cc_d = w_flags;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      occ_q    <= 3'b000;
      cc_q     <= CC_RESET;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      occ_q    <= occ_d;
      cc_q     <= cc_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_cc     = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_cc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_pipe_cc : directed + randomized bench for alu_pipe_cc.            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_alu_pipe_cc;

  localparam logic [2:0] CC_RST = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_set_cc, flush, out_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a, in_b;
  logic        in_ready, out_valid;
  logic [63:0] out_result;
  logic [2:0]  out_cc, cc_q;

  logic        in_valid8, in_set_cc8, flush8, out_ready8;
  logic [1:0]  in_op8;
  logic [7:0]  in_a8, in_b8;
  logic        in_ready8, out_valid8;
  logic [7:0]  out_result8;
  logic [2:0]  out_cc8, cc_q8;

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic [63:0] m_res;
  logic [2:0]  m_occ, m_cc;

  always #5 clk = ~clk;

  alu_pipe_cc #(.WIDTH(64), .CC_RESET(CC_RST)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cc(out_cc), .cc_q(cc_q)
  );

  alu_pipe_cc #(.WIDTH(8), .CC_RESET(CC_RST)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_op(in_op8), .in_a(in_a8), .in_b(in_b8), .in_set_cc(in_set_cc8),
    .flush(flush8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .out_cc(out_cc8), .cc_q(cc_q8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed math at 65 bits; overflow means the true result is out of range.
  task automatic ref64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic [2:0] f);
    logic signed [64:0] sa, sb, full, maxs, mins;
    logic of;
    sa   = $signed({a[63], a});
    sb   = $signed({b[63], b});
    maxs = (65'sd1 <<< 63) - 65'sd1;
    mins = -(65'sd1 <<< 63);
    of   = 1'b0;
    full = '0;
    case (op)
      2'd0: begin full = sb + sa; r = full[63:0]; of = (full > maxs) || (full < mins); end
      2'd1: begin full = sb - sa; r = full[63:0]; of = (full > maxs) || (full < mins); end
      2'd2: r = b & a;
      default: r = b ^ a;
    endcase
    f = {(r == 64'd0), ($signed(r) < 0), of};
  endtask

  task automatic cyc();
    logic [63:0] r;
    logic [2:0]  f;
    logic        acc;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
    ref64(in_op, in_a, in_b, r, f);
    if (!rst_n) begin
      m_valid = 1'b0; m_res = '0; m_occ = 3'b000; m_cc = CC_RST;
    end else begin
      acc = in_valid && (!m_valid || out_ready) && !flush;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1; m_res = r; m_occ = f;
        if (in_set_cc) m_cc = f;
      end else if (out_ready) m_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("out_valid",  {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_result", out_result, m_res);
    chk("out_cc",     {61'd0, out_cc}, {61'd0, m_occ});
    chk("cc_q",       {61'd0, cc_q},   {61'd0, m_cc});
  endtask

  task automatic op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                    input logic sc);
    in_valid = 1'b1; in_op = o; in_a = a; in_b = b; in_set_cc = sc;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h8000000000000000;
      2: return 64'h7FFFFFFFFFFFFFFF;
      3: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    m_valid = 1'b0; m_res = '0; m_occ = '0; m_cc = CC_RST;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op(2'd0, 64'd1, 64'd2, 1'b1);
    in_valid8 = 1'b0; in_set_cc8 = 1'b1; flush8 = 1'b0; out_ready8 = 1'b1;
    in_op8 = 2'd0; in_a8 = 8'd0; in_b8 = 8'd0;

    // Reset held two edges with an op presented
    @(posedge clk); #1;
    cyc();
    chk("rst_result", out_result, 64'd0);
    chk("rst_cc", {61'd0, cc_q}, {61'd0, 3'b100});
    in_valid = 1'b0; rst_n = 1'b1;
    #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    op(2'd2, 64'hCCCCCCCCCCCCCCCC, 64'hAAAAAAAAAAAAAAAA, 1'b1); cyc();
    chk("and1_res", out_result, 64'h8888888888888888);
    chk("and1_cc", {61'd0, cc_q}, {61'd0, 3'b010});
    op(2'd2, 64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1'b1); cyc();
    chk("and2_res", out_result, 64'd0);
    chk("and2_cc", {61'd0, cc_q}, {61'd0, 3'b100});

    op(2'd0, 64'd1, 64'h7FFFFFFFFFFFFFFF, 1'b1); cyc();
    chk("addov_res", out_result, 64'h8000000000000000);
    chk("addov_cc", {61'd0, cc_q}, {61'd0, 3'b011});

    op(2'd1, 64'd5, 64'd5, 1'b0); cyc();
    chk("sub1_res", out_result, 64'd0);
    chk("sub1_occ", {61'd0, out_cc}, {61'd0, 3'b100});
    chk("sub1_cc", {61'd0, cc_q}, {61'd0, 3'b011});
    op(2'd1, 64'd1, 64'h8000000000000000, 1'b0); cyc();
    chk("sub2_res", out_result, 64'h7FFFFFFFFFFFFFFF);
    chk("sub2_occ", {61'd0, out_cc}, {61'd0, 3'b001});

    // Backpressure: result held, second op waits at the source
    op(2'd3, 64'hFF, 64'h0F, 1'b1); cyc();
    out_ready = 1'b0;
    op(2'd0, 64'd3, 64'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_res", out_result, 64'hF0);
      chk("bp_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", {63'd0, in_ready}, 64'd1);
    cyc();
    chk("bp_second", out_result, 64'd7);

    // Flush with valid result and concurrent op
    op(2'd1, 64'd9, 64'd2, 1'b1); flush = 1'b1; cyc();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cc", {61'd0, cc_q}, {61'd0, 3'b000});
    flush = 1'b0; in_valid = 1'b0; cyc();

    // 8-bit instance
    in_valid = 1'b0;
    in_valid8 = 1'b1; in_op8 = 2'd0; in_a8 = 8'h01; in_b8 = 8'hFF; cyc();
    chk("w8_res", {56'd0, out_result8}, 64'd0);
    chk("w8_occ", {61'd0, out_cc8}, {61'd0, 3'b100});
    in_a8 = 8'h01; in_b8 = 8'h7F; cyc();
    chk("w8_ov_res", {56'd0, out_result8}, 64'h80);
    chk("w8_ov_cc", {61'd0, cc_q8}, {61'd0, 3'b011});
    in_valid8 = 1'b0;

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 79) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      in_set_cc = $urandom_range(0, 1) != 0;
      in_op     = 2'($urandom_range(0, 3));
      in_a      = rnd64();
      in_b      = rnd64();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
